// File: rtl/p4_router_queue_page_writer.sv
// p4_router_queue_page_writer
// Enqueue-side page writer for the queue MMU. Segments policed packets into
// fixed-size pages taken from the MMU free-page stream, writes beats into the
// paged buffer, chains pages in the link table and emits one descriptor per
// packet. Packets are dropped at SOP when fewer than an MTU's worth of pages
// are free; packets longer than the MTU are truncated and flagged.
// Optional: define P4_ROUTER_PAGE_WRITER_STATS_EN to add 64-bit packet/byte
// counters (stat_pkt_count, stat_byte_count).
module p4_router_queue_page_writer #(
    parameter int NUM_PAGES_LOG  = 10,
    parameter int PAGE_BYTES     = 256,
    parameter int DATA_BYTES     = 64,
    parameter int NUM_QUEUES_LOG = 3,
    parameter int MTU_BYTES      = 2000,
    localparam int W             = PAGE_BYTES / DATA_BYTES,
    localparam int WORD_LOG      = (W > 1) ? $clog2(W) : 1,
    localparam int PAGES_PER_MTU = (MTU_BYTES + PAGE_BYTES - 1) / PAGE_BYTES,
    localparam int LEN_W         = $clog2(MTU_BYTES + 1),
    localparam int NP_W          = $clog2(PAGES_PER_MTU + 1)
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [8*DATA_BYTES-1:0]           packet_in_tdata,
    input  logic [DATA_BYTES-1:0]             packet_in_tkeep,
    input  logic [NUM_QUEUES_LOG-1:0]         packet_in_tuser,
    input  logic                              packet_in_tlast,
    input  logic                              packet_in_tvalid,
    output logic                              packet_in_tready,
    input  logic [NUM_PAGES_LOG:0]            num_free_pages,
    input  logic [NUM_PAGES_LOG-1:0]          alloc_tdata,
    input  logic                              alloc_tvalid,
    output logic                              alloc_tready,
    output logic                              mem_wr_en,
    output logic [NUM_PAGES_LOG+WORD_LOG-1:0] mem_wr_addr,
    output logic [8*DATA_BYTES-1:0]           mem_wr_data,
    output logic                              link_wr_en,
    output logic [NUM_PAGES_LOG-1:0]          link_wr_addr,
    output logic [NUM_PAGES_LOG:0]            link_wr_data,
    output logic                              desc_tvalid,
    input  logic                              desc_tready,
    output logic [NUM_PAGES_LOG-1:0]          desc_head_page,
    output logic [LEN_W-1:0]                  desc_byte_len,
    output logic [NUM_QUEUES_LOG-1:0]         desc_queue,
    output logic [NP_W-1:0]                   desc_num_pages,
    output logic                              desc_err,
    output logic [31:0]                       drop_count
`ifdef P4_ROUTER_PAGE_WRITER_STATS_EN
    ,
    output logic [63:0]                       stat_pkt_count,
    output logic [63:0]                       stat_byte_count
`endif
);

    localparam int KC_W  = $clog2(DATA_BYTES + 1);
    localparam int SUM_W = $clog2(MTU_BYTES + DATA_BYTES + 1);
    localparam logic [NUM_PAGES_LOG:0] MIN_FREE = (NUM_PAGES_LOG+1)'(PAGES_PER_MTU);
    localparam logic [SUM_W-1:0]       MTU_LIM  = SUM_W'(MTU_BYTES);
    localparam logic [WORD_LOG-1:0]    LAST_WORD = WORD_LOG'(W - 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_TRUNC, S_DESC, S_DROP} state_t;

    state_t                     state;
    logic [NUM_PAGES_LOG-1:0]   spare_page;
    logic                       spare_valid;
    logic [NUM_PAGES_LOG-1:0]   cur_page;
    logic [WORD_LOG-1:0]        word_idx;
    logic                       link_pend;

    logic [KC_W-1:0]            keep_cnt;
    logic [SUM_W-1:0]           beat_bytes;
    logic [SUM_W-1:0]           len_next;
    logic                       over;
    logic                       need_page;
    logic                       first_page;
    logic                       stall;
    logic                       fire;
    logic                       wr_beat;
    logic                       take;
    logic [NUM_PAGES_LOG-1:0]   page_now;

    // Bytes carried by the tlast beat.
    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < DATA_BYTES; i++)
            keep_cnt = keep_cnt + KC_W'(packet_in_tkeep[i]);
    end

    // A beat that would push the packet past the MTU is not written; a page
    // boundary with no spare page stalls the input instead of losing data.
    always_comb begin
        beat_bytes = packet_in_tlast ? SUM_W'(keep_cnt) : SUM_W'(DATA_BYTES);
        len_next   = SUM_W'(desc_byte_len) + beat_bytes;
        over       = len_next > MTU_LIM;
        need_page  = (word_idx == '0);
        first_page = (desc_num_pages == '0);
        stall      = (state == S_WRITE) && need_page && !spare_valid && !over;
        packet_in_tready = ((state == S_WRITE) && !stall) ||
                           (state == S_TRUNC) || (state == S_DROP);
        fire       = packet_in_tvalid && packet_in_tready;
        wr_beat    = fire && (state == S_WRITE) && !over;
        take       = wr_beat && need_page;
        page_now   = take ? spare_page : cur_page;
        alloc_tready = !spare_valid;
        mem_wr_en   = wr_beat;
        mem_wr_addr = {page_now, word_idx};
        mem_wr_data = packet_in_tdata;
    end

    // Link-table writes. When a tlast beat opens a new page the forward link
    // owns this cycle and the terminal link is deferred to the first DESC cycle.
    always_comb begin
        link_wr_en   = 1'b0;
        link_wr_addr = cur_page;
        link_wr_data = '0;
        if ((state == S_DESC) && link_pend) begin
            link_wr_en   = 1'b1;
            link_wr_data = {1'b1, cur_page};
        end else if (take && !first_page) begin
            link_wr_en   = 1'b1;
            link_wr_data = {1'b0, spare_page};
        end else if (fire && packet_in_tlast &&
                     ((state == S_WRITE) || (state == S_TRUNC))) begin
            link_wr_en   = 1'b1;
            link_wr_addr = page_now;
            link_wr_data = {1'b1, page_now};
        end
    end

    // One-entry prefetch of a free page; refill only once the entry is empty.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            spare_valid <= 1'b0;
            spare_page  <= '0;
        end else if (take) begin
            spare_valid <= 1'b0;
        end else if (alloc_tvalid && !spare_valid) begin
            spare_valid <= 1'b1;
            spare_page  <= alloc_tdata;
        end
    end

    // Packet FSM: admission, page-by-page write, truncation, descriptor, drop.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= S_IDLE;
            cur_page       <= '0;
            word_idx       <= '0;
            link_pend      <= 1'b0;
            desc_tvalid    <= 1'b0;
            desc_head_page <= '0;
            desc_byte_len  <= '0;
            desc_queue     <= '0;
            desc_num_pages <= '0;
            desc_err       <= 1'b0;
            drop_count     <= '0;
        end else begin
            case (state)
                S_IDLE: if (packet_in_tvalid) begin
                    desc_queue     <= packet_in_tuser;
                    desc_byte_len  <= '0;
                    desc_num_pages <= '0;
                    desc_err       <= 1'b0;
                    word_idx       <= '0;
                    state          <= (num_free_pages < MIN_FREE) ? S_DROP : S_WRITE;
                end
                S_WRITE: if (fire) begin
                    if (over) begin
                        desc_err <= 1'b1;
                        if (packet_in_tlast) begin
                            desc_tvalid <= 1'b1;
                            state       <= S_DESC;
                        end else begin
                            state <= S_TRUNC;
                        end
                    end else begin
                        desc_byte_len <= len_next[LEN_W-1:0];
                        word_idx      <= (word_idx == LAST_WORD) ? '0 : word_idx + WORD_LOG'(1);
                        if (take) begin
                            cur_page       <= spare_page;
                            desc_num_pages <= desc_num_pages + NP_W'(1);
                            if (first_page)
                                desc_head_page <= spare_page;
                        end
                        if (packet_in_tlast) begin
                            link_pend   <= take && !first_page;
                            desc_tvalid <= 1'b1;
                            state       <= S_DESC;
                        end
                    end
                end
                S_TRUNC: if (fire && packet_in_tlast) begin
                    desc_tvalid <= 1'b1;
                    state       <= S_DESC;
                end
                S_DESC: begin
                    link_pend <= 1'b0;
                    if (desc_tready) begin
                        desc_tvalid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_DROP: if (fire && packet_in_tlast) begin
                    if (drop_count != '1)
                        drop_count <= drop_count + 32'd1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef P4_ROUTER_PAGE_WRITER_STATS_EN
    // Free-running packet and byte totals, counted at descriptor handshake.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stat_pkt_count  <= '0;
            stat_byte_count <= '0;
        end else if (desc_tvalid && desc_tready) begin
            stat_pkt_count  <= stat_pkt_count + 64'd1;
            stat_byte_count <= stat_byte_count + 64'(desc_byte_len);
        end
    end
`endif

endmodule
